// File: rtl/param_delay_line_if.sv
`default_nettype none
// ============================================================================
// Module      : param_delay_line_if
// Description : Data, valid and delay-select bundle for param_delay_line.
// Revision    : 1.0
// ============================================================================
interface param_delay_line_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 8,
    parameter int DW        = $clog2(MAX_DELAY)
);
    logic             ce;
    logic [WIDTH-1:0] d;
    logic             dv;
    logic [DW-1:0]    dly;
    logic [WIDTH-1:0] q;
    logic             qv;
    logic             busy;
    logic [DW-1:0]    dly_cur;

    modport master (
        output ce, d, dv, dly,
        input  q, qv, busy, dly_cur
    );

    modport slave (
        input  ce, d, dv, dly,
        output q, qv, busy, dly_cur
    );
endinterface
`default_nettype wire

// File: rtl/param_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : param_delay_line
// Description : Variable-latency pipeline (latency = dly_cur+1) with safe
//               delay switching; PARAM_DELAY_LINE_FLUSH_EN adds a flush input.
// Revision    : 1.0
// ============================================================================
module param_delay_line #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 8
) (
    input  wire logic clk,
    input  wire logic rst,
`ifdef PARAM_DELAY_LINE_FLUSH_EN
    input  wire logic flush,
`endif
    param_delay_line_if.slave bus
);
    localparam int DW = $clog2(MAX_DELAY);
    localparam int CW = $clog2(MAX_DELAY + 1);
    localparam logic [DW-1:0]        C_DLY_MAX = DW'(MAX_DELAY - 1);
    localparam logic [CW-1:0]        C_CNT_ONE = CW'(1);
    localparam logic [MAX_DELAY-1:0] C_ONES    = '1;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    logic [WIDTH-1:0]     r_data [MAX_DELAY];
    logic [MAX_DELAY-1:0] r_valid;
    logic [CW-1:0]        r_cnt;
    logic [DW-1:0]        r_dly_cur;
    state_t               r_state;

    logic [DW-1:0]        w_dly_clamp;
    logic [MAX_DELAY-1:0] w_keep;
    logic                 w_leave;
    logic [CW-1:0]        w_cnt_nxt;
    logic                 w_flush;

`ifdef PARAM_DELAY_LINE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    generate
        if (MAX_DELAY == (1 << DW)) begin : g_no_clamp
            assign w_dly_clamp = bus.dly;
        end else begin : g_clamp
            assign w_dly_clamp = (bus.dly > C_DLY_MAX) ? C_DLY_MAX : bus.dly;
        end
    endgenerate

    // A valid bit only advances while below the output tap; the one leaving the
    // tap is retired, so stages beyond dly_cur never hold a replayable sample.
    assign w_keep  = ~(C_ONES << r_dly_cur);
    assign w_leave = r_valid[r_dly_cur];

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.dv && !w_leave) begin
            w_cnt_nxt = r_cnt + C_CNT_ONE;
        end else if (!bus.dv && w_leave) begin
            w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_DELAY; k++) begin
                r_data[k] <= '0;
            end
            r_valid <= '0;
        end else begin
            if (bus.ce) begin
                r_data[0] <= bus.d;
                for (int k = 1; k < MAX_DELAY; k++) begin
                    r_data[k] <= r_data[k-1];
                end
            end
            if (w_flush) begin
                r_valid <= '0;
            end else if (bus.ce) begin
                r_valid <= {r_valid[MAX_DELAY-2:0] & w_keep[MAX_DELAY-2:0], bus.dv};
            end
        end
    end

    // Delay changes wait until nothing is in flight so no sample is lost or replayed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_dly_cur <= '0;
            r_state   <= ST_RUN;
        end else if (w_flush) begin
            r_cnt     <= '0;
            r_dly_cur <= w_dly_clamp;
            r_state   <= ST_RUN;
        end else if (bus.ce) begin
            r_cnt <= w_cnt_nxt;
            case (r_state)
                ST_RUN: begin
                    if (w_dly_clamp != r_dly_cur) begin
                        if (r_cnt == '0) begin
                            r_dly_cur <= w_dly_clamp;
                        end else begin
                            r_state <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (w_cnt_nxt == '0) begin
                        r_dly_cur <= w_dly_clamp;
                        r_state   <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign bus.q       = r_data[r_dly_cur];
    assign bus.qv      = r_valid[r_dly_cur];
    assign bus.busy    = (r_cnt != '0);
    assign bus.dly_cur = r_dly_cur;

endmodule
`default_nettype wire

// File: tb/tb_param_delay_line.sv
`default_nettype none
// Directed bench for param_delay_line (WIDTH=8, MAX_DELAY=8).
module tb_param_delay_line;
    logic clk;
    logic rst;
`ifdef PARAM_DELAY_LINE_FLUSH_EN
    logic flush;
`endif
    int checks;
    int errors;

    param_delay_line_if #(.WIDTH(8), .MAX_DELAY(8)) bus ();

    param_delay_line #(.WIDTH(8), .MAX_DELAY(8)) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef PARAM_DELAY_LINE_FLUSH_EN
        .flush(flush),
`endif
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
`ifdef PARAM_DELAY_LINE_FLUSH_EN
        flush = 1'b0;
`endif
        bus.ce = 1'b0; bus.d = 8'h00; bus.dv = 1'b0; bus.dly = 3'd0;
        tick();
        chk("rst_qv",   32'(bus.qv), 32'd0);
        chk("rst_q",    32'(bus.q), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_dly",  32'(bus.dly_cur), 32'd0);
        tick();
        rst = 1'b0;

        // Single sample, delay 3: visible exactly 4 edges after acceptance.
        bus.ce = 1'b1; bus.dly = 3'd3;
        tick();
        chk("t1_dly", 32'(bus.dly_cur), 32'd3);
        bus.dv = 1'b1; bus.d = 8'hA5;
        tick();
        bus.dv = 1'b0;
        chk("t1_busy1", 32'(bus.busy), 32'd1);
        chk("t1_qv1", 32'(bus.qv), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk("t1_qv", 32'(bus.qv), 32'(i == 4));
            chk("t1_busy", 32'(bus.busy), 32'(i <= 4));
            if (i == 4) chk("t1_q", 32'(bus.q), 32'hA5);
        end

        // Delay 0 back-to-back stream.
        bus.dly = 3'd0;
        tick();
        chk("t2_dly", 32'(bus.dly_cur), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            bus.dv = 1'b1; bus.d = 8'(i);
            tick();
            chk("t2_qv", 32'(bus.qv), 32'd1);
            chk("t2_q", 32'(bus.q), 32'(i));
        end
        bus.dv = 1'b0;
        tick();
        chk("t2_qv_end", 32'(bus.qv), 32'd0);
        chk("t2_busy_end", 32'(bus.busy), 32'd0);

        // Delay 5 stream, request delay 2 mid-stream; switch after last sample leaves.
        bus.dly = 3'd5;
        tick();
        chk("t3_dly0", 32'(bus.dly_cur), 32'd5);
        for (int t = 0; t <= 12; t++) begin
            bus.dv = (t <= 5);
            bus.d  = 8'(32'h20 + t);
            if (t == 3) bus.dly = 3'd2;
            tick();
            chk("t3_qv", 32'(bus.qv), 32'(t >= 5 && t <= 10));
            if (t >= 5 && t <= 10) chk("t3_q", 32'(bus.q), 32'(32'h20 + t - 5));
            chk("t3_dly", 32'(bus.dly_cur), (t >= 11) ? 32'd2 : 32'd5);
            chk("t3_busy", 32'(bus.busy), 32'(t <= 10));
        end
        bus.dv = 1'b1; bus.d = 8'h77;
        tick();
        bus.dv = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("t3_new_qv", 32'(bus.qv), 32'(i == 2));
            if (i == 2) chk("t3_new_q", 32'(bus.q), 32'h77);
        end

        // Delay 2 with clock-enable gaps.
        bus.dv = 1'b1; bus.d = 8'h11;
        tick();
        bus.dv = 1'b0; bus.ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_qv0", 32'(bus.qv), 32'd0);
            chk("t4_hold_busy", 32'(bus.busy), 32'd1);
        end
        bus.ce = 1'b1;
        tick();
        chk("t4_qv_e1", 32'(bus.qv), 32'd0);
        tick();
        chk("t4_qv", 32'(bus.qv), 32'd1);
        chk("t4_q", 32'(bus.q), 32'h11);
        bus.ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_held_qv", 32'(bus.qv), 32'd1);
            chk("t4_held_q", 32'(bus.q), 32'h11);
        end
        bus.ce = 1'b1;
        tick();
        chk("t4_after_qv", 32'(bus.qv), 32'd0);
        chk("t4_after_busy", 32'(bus.busy), 32'd0);

        // Delay 7 with 4 in flight, then asynchronous reset mid-cycle.
        bus.dly = 3'd7;
        tick();
        chk("t5_dly", 32'(bus.dly_cur), 32'd7);
        for (int i = 0; i < 4; i++) begin
            bus.dv = 1'b1; bus.d = 8'(32'h30 + i);
            tick();
        end
        bus.dv = 1'b0;
        chk("t5_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_qv", 32'(bus.qv), 32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_dly", 32'(bus.dly_cur), 32'd0);
        #2;
        rst = 1'b0;
        bus.dly = 3'd0; bus.dv = 1'b1; bus.d = 8'h5A;
        tick();
        chk("t5_first_qv", 32'(bus.qv), 32'd1);
        chk("t5_first_q", 32'(bus.q), 32'h5A);
        bus.dv = 1'b0;
        bus.dly = 3'd7;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_stale_qv", 32'(bus.qv), 32'd0);
        end

`ifdef PARAM_DELAY_LINE_FLUSH_EN
        // Flush with delay 6 and 3 in flight; new delay 1 applies at once.
        bus.dly = 3'd6;
        tick();
        chk("t6_dly", 32'(bus.dly_cur), 32'd6);
        for (int i = 0; i < 3; i++) begin
            bus.dv = 1'b1; bus.d = 8'(32'h40 + i);
            tick();
        end
        flush = 1'b1; bus.dv = 1'b1; bus.d = 8'h99; bus.dly = 3'd1;
        tick();
        flush = 1'b0; bus.dv = 1'b0;
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_dly1", 32'(bus.dly_cur), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_qv", 32'(bus.qv), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/param_delay_line.md
PARAM_DELAY_LINE -- requirements
Module: param_delay_line

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>=1) SHALL be provided.
REQ-002 Parameter MAX_DELAY, default 8, number of pipeline stages (2..256) SHALL be provided.
REQ-003 Derived localparam DW = clog2(MAX_DELAY) SHALL size the delay-select ports.
REQ-004 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 Ce  input  1  SHALL be the clock enable; low = whole pipeline holds.
REQ-007 D  input  WIDTH  SHALL be the input data.
REQ-008 Dv  input  1  SHALL mark D valid.
REQ-009 Dly  input  DW  SHALL be the requested delay select; latency = Dly+1 cycles.
REQ-010 Q  output  WIDTH  SHALL be the delayed data.
REQ-011 Qv  output  1  SHALL be the delayed valid.
REQ-012 Busy  output  1  SHALL be high while any valid sample is in flight.
REQ-013 DlyCur  output  DW  SHALL show the delay currently in effect.

Function
REQ-014 MAX_DELAY stages, each holding {data, valid}; with Ce high, stage 0 loads {D, Dv} and stage k loads stage k-1.
REQ-015 Q/Qv SHALL be driven from stage DlyCur (registered, no combinational path from D/Dv).
REQ-016 With Ce low, all stages, the in-flight counter, and DlyCur SHALL hold; Q/Qv SHALL hold.
REQ-017 Dly values >= MAX_DELAY SHALL be clamped to MAX_DELAY-1.
REQ-018 An in-flight counter (width clog2(MAX_DELAY+1)) SHALL count valid samples in stages 0..DlyCur: +1 on accepted Dv, -1 on Qv leaving stage DlyCur, both same cycle = no change.
REQ-019 Busy SHALL equal (counter != 0).
REQ-020 Delay-change FSM states: RUN, PEND.
REQ-021 RUN: if clamped Dly == DlyCur, stay; else if Busy low, load DlyCur on that edge, stay RUN; else latch target, go PEND.
REQ-022 PEND: Dv SHALL still be accepted; on the first Ce-high edge with counter reaching 0, load DlyCur from the latest clamped Dly, go RUN.
REQ-023 Data samples SHALL never be dropped or duplicated by a delay change; every accepted sample emerges exactly once.
REQ-024 Counter SHALL saturate neither direction beyond 0..MAX_DELAY; underflow is unreachable by construction.

Reset
REQ-025 On Rst high, all stage data and valids SHALL clear to 0 asynchronously.
REQ-026 Reset values: Q=0, Qv=0, Busy=0, DlyCur=0, counter=0, FSM=RUN.
REQ-027 Reset mid-operation SHALL discard all in-flight samples and any pending delay change.
REQ-028 First Dv SHALL be accepted on the first rising edge after Rst deasserts.

Configuration
REQ-029 Macro PARAM_DELAY_LINE_FLUSH_EN SHALL compile in input Flush (1 bit).
REQ-030 With macro defined: Flush high on an edge clears all stage valids and the counter, applies clamped Dly to DlyCur immediately, FSM to RUN, regardless of Ce; Flush beats Dv same cycle (sample dropped).
REQ-031 Without macro: no Flush port; delay changes only via REQ-021/022.

Verification (WIDTH=8, MAX_DELAY=8)
REQ-032 Dly=3, Dv=1 D=0xA5 single cycle -> Qv=1 Q=0xA5 exactly 4 cycles later, Busy high for those 4 cycles.
REQ-033 Dly=0, stream D=1..10 back-to-back -> Q=1..10 each one cycle later, no gaps.
REQ-034 Dly=5 streaming, switch Dly=2 mid-stream -> DlyCur stays 5 until counter hits 0, then 2; no sample lost or duplicated.
REQ-035 Dly=2, D=0x11 accepted, Ce low 3 cycles -> Q output after 3 enabled cycles; Qv and Q held while Ce low.
REQ-036 Dly=7 with 4 samples in flight, Rst pulse -> Qv=0, Busy=0, DlyCur=0 immediately; no stale output afterward.
REQ-037 FLUSH_EN defined: Dly=6, 3 in flight, Flush+Dv together with Dly=1 -> Busy=0 next cycle, DlyCur=1, no Qv ever from flushed samples.
